// File: rtl/cpu_wb_arbiter.sv
// Two-master Wishbone arbiter (instruction + data) in front of one shared memory.
// Round-robin on ties; owner keeps the bus while its cyc is high; stall timeout raises err.
module cpu_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADR_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             mI_cyc_i,
  input  logic             mI_stb_i,
  input  logic             mI_we_i,
  input  logic [ADR_W-1:0] mI_adr_i,
  input  logic [31:0]      mI_dat_i,
  input  logic [3:0]       mI_sel_i,
  output logic [31:0]      mI_dat_o,
  output logic             mI_ack_o,
  output logic             mI_err_o,
  input  logic             mD_cyc_i,
  input  logic             mD_stb_i,
  input  logic             mD_we_i,
  input  logic [ADR_W-1:0] mD_adr_i,
  input  logic [31:0]      mD_dat_i,
  input  logic [3:0]       mD_sel_i,
  output logic [31:0]      mD_dat_o,
  output logic             mD_ack_o,
  output logic             mD_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [31:0]      s_dat_o,
  output logic [3:0]       s_sel_o,
  input  logic [31:0]      s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       grant_o
);

  typedef enum logic [1:0] {IDLE = 2'b00, OWN_I = 2'b01, OWN_D = 2'b10} state_e;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        last_is_d_q, last_is_d_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        req_i, req_d, own_i, own_d, stall, timeout;

  assign req_i = mI_cyc_i & mI_stb_i;
  assign req_d = mD_cyc_i & mD_stb_i;
  assign own_i = (state_q == OWN_I);
  assign own_d = (state_q == OWN_D);

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    case (state_q)
      OWN_I: begin
        s_cyc_o = mI_cyc_i; s_stb_o = mI_stb_i; s_we_o  = mI_we_i;
        s_adr_o = mI_adr_i; s_dat_o = mI_dat_i; s_sel_o = mI_sel_i;
      end
      OWN_D: begin
        s_cyc_o = mD_cyc_i; s_stb_o = mD_stb_i; s_we_o  = mD_we_i;
        s_adr_o = mD_adr_i; s_dat_o = mD_dat_i; s_sel_o = mD_sel_i;
      end
      default: ;
    endcase
  end

  // Timeout fires during the final stall cycle, so err can never coincide with ack.
  assign stall   = s_stb_o & ~s_ack_i;
  assign timeout = TO_EN & stall & (cnt_q == TO_LAST);

  assign mI_ack_o = s_ack_i & own_i & s_stb_o;
  assign mD_ack_o = s_ack_i & own_d & s_stb_o;
  assign mI_err_o = own_i & timeout;
  assign mD_err_o = own_d & timeout;
  assign mI_dat_o = s_dat_i;
  assign mD_dat_o = s_dat_i;
  assign grant_o  = grant_q;

  always_comb begin
    state_d     = state_q;
    last_is_d_d = last_is_d_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_i && (!req_d || last_is_d_q)) begin
          state_d     = OWN_I;
          last_is_d_d = 1'b0;
        end else if (req_d) begin
          state_d     = OWN_D;
          last_is_d_d = 1'b1;
        end
      end
      default: begin
        if (s_ack_i)                            cnt_d = '0;
        else if (s_stb_o && cnt_q != 16'hFFFF)  cnt_d = cnt_q + 16'd1;
        if (timeout || !s_cyc_o) state_d = IDLE;
      end
    endcase
    grant_d = {state_d == OWN_D, state_d == OWN_I};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_is_d_q <= 1'b1;
      cnt_q       <= '0;
      grant_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_is_d_q <= last_is_d_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
    end
  end

endmodule
